// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI read-channel constants and the read-arbiter state type.
//   AXI_BURST_WRAP / AXI_SIZE_8B / AXI_PROT_DEFAULT / AXI_CACHE_DEFAULT drive the
//   constant AR fields; AXI_RESP_OKAY is the only response treated as clean.
package axi_pkg;

    localparam logic [1:0] AXI_BURST_WRAP    = 2'h2;
    localparam logic [2:0] AXI_SIZE_8B       = 3'h3;
    localparam logic [2:0] AXI_PROT_DEFAULT  = 3'h6;
    localparam logic [3:0] AXI_CACHE_DEFAULT = 4'h0;
    localparam logic [1:0] AXI_RESP_OKAY     = 2'h0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_t;

    // One-hot requester mask from a requester index.
    function automatic logic [1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin grant.
//   clk, reset : clock, synchronous active-high reset (pointer back to requester 0)
//   req        : request vector, bit n = requester n
//   done       : completion strobe for the transaction granted to done_idx
//   done_idx   : requester that just completed; pointer moves to the other one
//   grant_c    : index of the winning requester (combinational)
//   any_c      : at least one requester is asking (combinational)
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       done,
    input  logic       done_idx,
    output logic       grant_c,
    output logic       any_c
);

    logic rr_ptr;

    // Priority pointer: the requester that did not just complete goes first next time.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr <= 1'b0;
        end else if (done) begin
            rr_ptr <= ~done_idx;
        end
    end

    // Contention resolved by the pointer; a lone requester always wins.
    always_comb begin
        any_c   = |req;
        grant_c = (req == 2'b11) ? rr_ptr : req[1];
    end

endmodule

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: shares one AXI read channel (AR/R) between two line-fill
// requesters (0 = instruction fetch, 1 = data load). One transaction at a time:
// grant, issue a single wrap burst on AR, route the R beats back to the winner.
//   clk, reset        : clock, synchronous active-high reset
//   req_valid[1:0]    : request per requester; address held until req_ready
//   req_addr0/1       : requester addresses (aligned down to the beat size)
//   req_ready[1:0]    : one-cycle accept pulse to the granted requester
//   resp_valid[1:0]   : beat valid to requester n, zero-latency from R
//   resp_data/last/err: shared beat payload, last-beat flag, beat error flag
//   m_axi_ar*         : read address channel (constant burst attributes)
//   m_axi_r*          : read data channel; rready only while collecting a burst
module axi_read_arbiter
    import axi_pkg::*;
#(
    parameter int unsigned ID_WIDTH   = 13,
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic [1:0]            req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    output logic [1:0]            req_ready,

    output logic [1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_last,
    output logic                  resp_err,

    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam int unsigned BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0]     LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
    // Clears the byte-offset bits of an 8-byte beat.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(7);

    arb_state_t            state;
    logic                  grant_idx;
    logic [BEAT_W-1:0]     beat_cnt;

    logic                  arb_grant_c;
    logic                  arb_any_c;
    logic                  beat_c;
    logic                  done_c;
    logic [ADDR_WIDTH-1:0] sel_addr_c;

    rr_arb2 u_rr_arb2 (
        .clk      (clk),
        .reset    (reset),
        .req      (req_valid),
        .done     (done_c),
        .done_idx (grant_idx),
        .grant_c  (arb_grant_c),
        .any_c    (arb_any_c)
    );

    // Burst attributes never change: one fixed-length 8-byte wrap burst per line fill.
    assign m_axi_arlen   = 8'(BURST_LEN - 1);
    assign m_axi_arsize  = AXI_SIZE_8B;
    assign m_axi_arburst = AXI_BURST_WRAP;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = AXI_CACHE_DEFAULT;
    assign m_axi_arprot  = AXI_PROT_DEFAULT;

    // Beat acceptance, beat routing and per-beat error detection.
    always_comb begin
        sel_addr_c = arb_grant_c ? req_addr1 : req_addr0;
        beat_c     = m_axi_rvalid && m_axi_rready && (state == DATA);
        done_c     = beat_c && m_axi_rlast;
        resp_valid = beat_c ? req_onehot(grant_idx) : 2'b00;
        resp_data  = m_axi_rdata;
        resp_last  = beat_c && m_axi_rlast;
        // Flags bad response, foreign ID, early rlast, or missing rlast on the final beat.
        resp_err   = beat_c && ((m_axi_rresp != AXI_RESP_OKAY) ||
                                (m_axi_rid != m_axi_arid) ||
                                (m_axi_rlast && (beat_cnt != LAST_BEAT)) ||
                                (!m_axi_rlast && (beat_cnt == LAST_BEAT)));
    end

    // Transaction sequencer: IDLE -> ADDR -> DATA -> IDLE, all handshake outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            grant_idx     <= 1'b0;
            beat_cnt      <= '0;
            req_ready     <= 2'b00;
            m_axi_arvalid <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arid    <= '0;
            m_axi_rready  <= 1'b0;
        end else begin
            req_ready <= 2'b00;
            case (state)
                IDLE: begin
                    if (arb_any_c) begin
                        grant_idx     <= arb_grant_c;
                        m_axi_araddr  <= sel_addr_c & ALIGN_MASK;
                        m_axi_arid    <= ID_WIDTH'(arb_grant_c);
                        req_ready     <= req_onehot(arb_grant_c);
                        m_axi_arvalid <= 1'b1;
                        state         <= ADDR;
                    end
                end
                ADDR: begin
                    if (m_axi_arvalid && m_axi_arready) begin
                        m_axi_arvalid <= 1'b0;
                        m_axi_rready  <= 1'b1;
                        beat_cnt      <= '0;
                        state         <= DATA;
                    end
                end
                DATA: begin
                    if (beat_c) begin
                        // Saturate so an overlong burst keeps flagging the final-beat checks.
                        if (beat_cnt != LAST_BEAT) begin
                            beat_cnt <= beat_cnt + BEAT_W'(1);
                        end
                        if (m_axi_rlast) begin
                            m_axi_rready <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Testbench for axi_read_arbiter: a scripted AXI slave drives AR/R, expected
// response beats go into a scoreboard queue and are checked as they emerge.
module tb_axi_read_arbiter;

    localparam int ID_WIDTH   = 13;
    localparam int ADDR_WIDTH = 64;
    localparam int DATA_WIDTH = 64;
    localparam int BURST_LEN  = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [1:0]            req_valid;
    logic [ADDR_WIDTH-1:0] req_addr0;
    logic [ADDR_WIDTH-1:0] req_addr1;
    logic [1:0]            req_ready;
    logic [1:0]            resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  resp_last;
    logic                  resp_err;
    logic [ID_WIDTH-1:0]   m_axi_arid;
    logic [ADDR_WIDTH-1:0] m_axi_araddr;
    logic [7:0]            m_axi_arlen;
    logic [2:0]            m_axi_arsize;
    logic [1:0]            m_axi_arburst;
    logic                  m_axi_arlock;
    logic [3:0]            m_axi_arcache;
    logic [2:0]            m_axi_arprot;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;
    logic [ID_WIDTH-1:0]   m_axi_rid;
    logic [DATA_WIDTH-1:0] m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rlast;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    axi_read_arbiter #(
        .ID_WIDTH   (ID_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BURST_LEN  (BURST_LEN)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_addr0     (req_addr0),
        .req_addr1     (req_addr1),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_last     (resp_last),
        .resp_err      (resp_err),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arlock  (m_axi_arlock),
        .m_axi_arcache (m_axi_arcache),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rid     (m_axi_rid),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rlast   (m_axi_rlast),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid;
        logic [63:0] data;
        logic        last;
        logic        err;
    } beat_t;

    beat_t sb_q[$];
    int    n_checks = 0;
    int    n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Response monitor: every forwarded beat must match the head of the scoreboard.
    always @(negedge clk) begin : monitor
        beat_t e;
        if (resp_valid != 2'b00) begin
            if (sb_q.size() == 0) begin
                check_eq("unexpected_beat", 64'(resp_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check_eq("resp_valid", 64'(resp_valid), 64'(e.valid));
                check_eq("resp_data", resp_data, e.data);
                check_eq("resp_last", 64'(resp_last), 64'(e.last));
                check_eq("resp_err", 64'(resp_err), 64'(e.err));
            end
        end
    end

    // Wait (bounded) for the accept pulse, check it, drop the granted request.
    task automatic wait_grant(input logic [1:0] exp);
        int t = 0;
        while (req_ready == 2'b00 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("req_ready", 64'(req_ready), 64'(exp));
        req_valid = req_valid & ~exp;
        @(negedge clk);
        check_eq("req_ready_pulse", 64'(req_ready), 64'd0);
    endtask

    // Check the AR request, stall it for 'delay' cycles, then complete the handshake.
    task automatic serve_ar(input logic [63:0] exp_addr, input logic [12:0] exp_id, input int delay);
        int t = 0;
        while (m_axi_arvalid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("arvalid", 64'(m_axi_arvalid), 64'd1);
        check_eq("araddr", m_axi_araddr, exp_addr);
        check_eq("arid", 64'(m_axi_arid), 64'(exp_id));
        check_eq("arlen", 64'(m_axi_arlen), 64'd7);
        check_eq("arburst", 64'(m_axi_arburst), 64'd2);
        for (int k = 0; k < delay; k++) begin
            @(negedge clk);
            check_eq("arvalid_hold", 64'(m_axi_arvalid), 64'd1);
            check_eq("araddr_hold", m_axi_araddr, exp_addr);
            check_eq("rready_wait", 64'(m_axi_rready), 64'd0);
        end
        m_axi_arready = 1'b1;
        @(negedge clk);
        m_axi_arready = 1'b0;
        check_eq("arvalid_drop", 64'(m_axi_arvalid), 64'd0);
        check_eq("rready_on", 64'(m_axi_rready), 64'd1);
    endtask

    // Drive n back-to-back R beats and push the expected forwarded beats.
    task automatic serve_beats(input int port, input logic [12:0] id, input int n,
                               input int last_idx, input int err_beat, input int bad_id_beat);
        for (int i = 0; i < n; i++) begin
            beat_t e;
            int    cnt;
            logic  lst;
            @(posedge clk);
            #1;
            cnt = (i > BURST_LEN - 1) ? BURST_LEN - 1 : i;
            lst = (i == last_idx);
            m_axi_rvalid = 1'b1;
            m_axi_rdata  = 64'hA0 + 64'(i);
            m_axi_rresp  = (i == err_beat) ? 2'b10 : 2'b00;
            m_axi_rlast  = lst;
            m_axi_rid    = (i == bad_id_beat) ? (id ^ 13'h5) : id;
            e.valid = (port == 1) ? 2'b10 : 2'b01;
            e.data  = 64'hA0 + 64'(i);
            e.last  = lst;
            e.err   = (i == err_beat) || (i == bad_id_beat) ||
                      (lst && cnt != BURST_LEN - 1) || (!lst && cnt == BURST_LEN - 1);
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        m_axi_rvalid = 1'b0;
        m_axi_rlast  = 1'b0;
        m_axi_rresp  = 2'b00;
        @(negedge clk);
        check_eq("sb_drained", 64'(sb_q.size()), 64'd0);
        check_eq("rready_after", 64'(m_axi_rready), (last_idx < n) ? 64'd0 : 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        beat_t e;
        reset         = 1'b1;
        req_valid     = 2'b00;
        req_addr0     = '0;
        req_addr1     = '0;
        m_axi_arready = 1'b0;
        m_axi_rid     = '0;
        m_axi_rdata   = '0;
        m_axi_rresp   = 2'b00;
        m_axi_rlast   = 1'b0;
        m_axi_rvalid  = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check_eq("rst_rready", 64'(m_axi_rready), 64'd0);
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_araddr", m_axi_araddr, 64'd0);
        check_eq("rst_arid", 64'(m_axi_arid), 64'd0);
        check_eq("rst_arlen", 64'(m_axi_arlen), 64'h7);
        check_eq("rst_arsize", 64'(m_axi_arsize), 64'h3);
        check_eq("rst_arburst", 64'(m_axi_arburst), 64'h2);
        check_eq("rst_arlock", 64'(m_axi_arlock), 64'h0);
        check_eq("rst_arcache", 64'(m_axi_arcache), 64'h0);
        check_eq("rst_arprot", 64'(m_axi_arprot), 64'h6);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Single request from requester 0
        req_addr0 = 64'h1000_0013;
        req_valid = 2'b01;
        wait_grant(2'b01);
        serve_ar(64'h1000_0010, 13'd0, 0);
        serve_beats(0, 13'd0, 8, 7, -1, -1);

        // Simultaneous requests right after reset: 0 first, then 1
        @(posedge clk); #1; reset = 1'b1;
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        req_addr0 = 64'h2000_0008;
        req_addr1 = 64'h3000_0027;
        req_valid = 2'b11;
        wait_grant(2'b01);
        serve_ar(64'h2000_0008, 13'd0, 0);
        serve_beats(0, 13'd0, 8, 7, -1, -1);
        wait_grant(2'b10);
        serve_ar(64'h3000_0020, 13'd1, 0);
        serve_beats(1, 13'd1, 8, 7, -1, -1);

        // AR backpressure for 5 cycles
        req_addr1 = 64'h4000_0100;
        req_valid = 2'b10;
        wait_grant(2'b10);
        serve_ar(64'h4000_0100, 13'd1, 5);
        serve_beats(1, 13'd1, 8, 7, -1, -1);

        // Error response on beat 3
        req_addr0 = 64'h5000_0044;
        req_valid = 2'b01;
        wait_grant(2'b01);
        serve_ar(64'h5000_0040, 13'd0, 0);
        serve_beats(0, 13'd0, 8, 7, 3, -1);

        // Early rlast on beat 5
        req_addr1 = 64'h6000_0001;
        req_valid = 2'b10;
        wait_grant(2'b10);
        serve_ar(64'h6000_0000, 13'd1, 0);
        serve_beats(1, 13'd1, 6, 5, -1, -1);

        // Next request after early rlast: wrong rid on beat 2, overlong burst (rlast on beat 8)
        req_addr0 = 64'h7000_00F8;
        req_valid = 2'b01;
        wait_grant(2'b01);
        serve_ar(64'h7000_00F8, 13'd0, 0);
        serve_beats(0, 13'd0, 9, 8, -1, 2);

        // Reset during beat 4 of a requester-1 burst
        req_addr1 = 64'h8000_0010;
        req_valid = 2'b10;
        wait_grant(2'b10);
        serve_ar(64'h8000_0010, 13'd1, 0);
        serve_beats(1, 13'd1, 4, 99, -1, -1);
        @(posedge clk);
        #1;
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = 64'hA4;
        m_axi_rid    = 13'd1;
        m_axi_rresp  = 2'b00;
        m_axi_rlast  = 1'b0;
        reset        = 1'b1;
        e.valid = 2'b10;
        e.data  = 64'hA4;
        e.last  = 1'b0;
        e.err   = 1'b0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        reset       = 1'b0;
        m_axi_rdata = 64'hA5;
        @(negedge clk);
        check_eq("post_rst_arvalid", 64'(m_axi_arvalid), 64'd0);
        check_eq("post_rst_rready", 64'(m_axi_rready), 64'd0);
        check_eq("post_rst_resp_valid", 64'(resp_valid), 64'd0);
        check_eq("post_rst_sb", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
        m_axi_rvalid = 1'b0;

        // Pointer back to requester 0 after reset, then requester 1 served
        req_addr0 = 64'h9000_0000;
        req_addr1 = 64'hA000_0018;
        req_valid = 2'b11;
        wait_grant(2'b01);
        serve_ar(64'h9000_0000, 13'd0, 0);
        serve_beats(0, 13'd0, 8, 7, -1, -1);
        wait_grant(2'b10);
        serve_ar(64'hA000_0018, 13'd1, 0);
        serve_beats(1, 13'd1, 8, 7, -1, -1);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
Shares the single AXI read channel (AR/R) between two line-fill requesters: port 0 (instruction fetch) and port 1 (data load).
- Accepts one request at a time, issues one wrap burst on AR, and routes the R beats back to the granted requester.
- Sits between the core front end and the top-level m_axi_* read ports; the write channels are untouched.

Parameters:
ID_WIDTH, 13, AXI ID width
ADDR_WIDTH, 64, AXI address width
DATA_WIDTH, 64, AXI data width; one beat per cycle
BURST_LEN, 8, beats per burst; arlen = BURST_LEN-1

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  2  per-requester request valid; bit n = requester n
req_addr0  in  ADDR_WIDTH  requester 0 address
req_addr1  in  ADDR_WIDTH  requester 1 address
req_ready  out  2  one-cycle accept pulse per requester
resp_valid  out  2  beat valid for requester n
resp_data  out  DATA_WIDTH  beat data, shared by both requesters
resp_last  out  1  final beat of the burst
resp_err  out  1  error flag on the current beat
m_axi_arid  out  ID_WIDTH  read ID
m_axi_araddr  out  ADDR_WIDTH  read address
m_axi_arlen  out  8  burst length - 1
m_axi_arsize  out  3  beat size
m_axi_arburst  out  2  burst type
m_axi_arlock  out  1  lock
m_axi_arcache  out  4  cache attributes
m_axi_arprot  out  3  protection attributes
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_rid  in  ID_WIDTH  read ID
m_axi_rdata  in  DATA_WIDTH  read data
m_axi_rresp  in  2  read response
m_axi_rlast  in  1  last beat
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready

Behaviour:
- Reset (synchronous, active-high; clock clk):
  - state=IDLE, rr_ptr=0 (requester 0 has priority), beat_cnt=0.
  - arvalid=0, rready=0, req_ready=0, araddr=0, arid=0.
  - Constant AR fields: arlen=BURST_LEN-1 (8'h7), arsize=3'h3, arburst=2'h2 (WRAP), arlock=0, arcache=0, arprot=3'h6.
- Reset mid-burst: abandon the transaction and return to IDLE; outstanding R beats are not tracked afterwards.
- IDLE:
  - If any req_valid bit is set, grant per rr_ptr: requester rr_ptr wins when both request, otherwise the single requester wins.
  - Register araddr = {req_addrN[63:3], 3'b0} and arid = grant index zero-extended.
  - Pulse req_ready[N] for exactly that cycle; next state ADDR.
  - A requester must hold its address until req_ready.
- ADDR:
  - arvalid=1; araddr and arid stay stable until arready.
  - On arvalid&&arready: arvalid<=0, rready<=1, beat_cnt<=0, state DATA.
  - No combinational path from arready to arvalid.
- DATA:
  - rready=1. Each rvalid beat forwards combinationally, zero latency:
    - resp_valid[grant]=1, resp_data=rdata, resp_last=rlast.
  - resp_err=1 if any of:
    - rresp≠0
    - rid≠arid
    - rlast set with beat_cnt≠BURST_LEN-1
    - beat_cnt==BURST_LEN-1 without rlast
  - beat_cnt increments per beat and saturates at BURST_LEN-1.
  - On rvalid&&rlast: rready<=0, rr_ptr<=~grant, state IDLE.
  - Requesters have no backpressure; they must sink one beat per cycle.
- New requests are not accepted until the cycle after the last beat (IDLE is re-entered); at most one transaction is outstanding.
- resp_valid is 0 outside DATA; rvalid seen in IDLE or ADDR is ignored (rready=0).
- Starvation freedom: with both requesting continuously, grants alternate 0,1,0,1.

Decomposition:
- Shared package axi_pkg:
  - constants: AXI_BURST_WRAP=2'h2, AXI_SIZE_8B=3'h3, AXI_PROT_DEFAULT=3'h6, AXI_RESP_OKAY=2'h0
  - typedef arb_state_t {IDLE, ADDR, DATA}
- One sub-module, rr_arb2: a 2-way round-robin grant with pointer update on a completion strobe.

Test Plan:
- Single request: req_valid=2'b01, addr0=0x1000_0013 -> req_ready=01 for 1 cycle; araddr=0x1000_0010, arid=0, arlen=7, arburst=2; 8 beats 0xA0..0xA7 appear on resp_data with resp_valid=01; resp_last on the 8th beat.
- Simultaneous requests after reset: req_valid=11 -> requester 0 granted first, requester 1 granted second (arid=1); resp_valid=10 during the second burst.
- AR backpressure: arready held low 5 cycles -> arvalid stays 1 with araddr stable; DATA is entered only after the handshake.
- Error beat: beat 3 has rresp=2'b10 -> resp_err=1 on that beat only; the burst still completes and returns to IDLE.
- Early rlast on beat 5 -> resp_err=1 and resp_last=1 on that beat; state IDLE; next request is accepted normally.
- Reset asserted during beat 4 -> next cycle arvalid=0, rready=0, resp_valid=00, rr_ptr=0; a subsequent request from requester 1 alone is granted.
